// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32 decode stage with register file,
// load-use interlock and a single registered output slot.
module id_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  output logic            out_valid,
  output logic [10:0]     ctrl,
  output logic [XLEN-1:0] dataA,
  output logic [XLEN-1:0] dataB,
  output logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            ill,
  output logic [15:0]     stall_cnt
);

  typedef struct packed {
    logic [10:0]     ctrl;
    logic            ill;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pcv;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } id_ex_t;

  localparam logic [10:0] CTRL_R  = 11'b100_0001_0000;
  localparam logic [10:0] CTRL_I  = 11'b110_0001_0000;
  localparam logic [10:0] CTRL_LD = 11'b110_1100_0000;
  localparam logic [10:0] CTRL_ST = 11'b011_0000_0001;
  localparam logic [10:0] CTRL_BR = 11'b000_0010_1010;
  localparam logic [5:0]  NREG_L  = 6'(NREG);
  localparam bit          BYP     = (BYPASS != 0);

  logic [XLEN-1:0] rf_q [32];
  id_ex_t          q_q, q_d, dec;
  logic            valid_q, valid_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [6:0]      opc;
  logic [4:0]      f_rs1, f_rs2, f_rd;
  logic            is_r, is_i, is_ld, is_st, is_br;
  logic            uses_rs2, hazard, adv, xfer, wb_we;
  logic            ok1, ok2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic [XLEN-1:0] rf_a, rf_b;
  logic            unused_ok;

  assign opc   = instruction[6:0];
  assign f_rd  = instruction[11:7];
  assign f_rs1 = instruction[19:15];
  assign f_rs2 = instruction[24:20];
  assign unused_ok = ^instruction[14:12];

  assign is_r  = (opc == 7'b0110011);
  assign is_i  = (opc == 7'b0010011);
  assign is_ld = (opc == 7'b0000011);
  assign is_st = (opc == 7'b0100011);
  assign is_br = (opc == 7'b1100011);

  assign imm_i = {{(XLEN-12){instruction[31]}},
                  instruction[31:20]};
  assign imm_s = {{(XLEN-12){instruction[31]}},
                  instruction[31:25], instruction[11:7]};
  assign imm_b = {{(XLEN-13){instruction[31]}},
                  instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};

  // x0 and indices beyond NREG are hardwired to zero
  assign wb_we = wb_en && (wb_rd != 5'd0)
              && ({1'b0, wb_rd} < NREG_L);
  assign ok1 = (f_rs1 != 5'd0) && ({1'b0, f_rs1} < NREG_L);
  assign ok2 = (f_rs2 != 5'd0) && ({1'b0, f_rs2} < NREG_L);

  assign rf_a = !ok1 ? '0
              : (BYP && wb_we && wb_rd == f_rs1) ? wb_data
              : rf_q[f_rs1];
  assign rf_b = !ok2 ? '0
              : (BYP && wb_we && wb_rd == f_rs2) ? wb_data
              : rf_q[f_rs2];

  always_comb begin
    dec      = '0;
    dec.a    = rf_a;
    dec.b    = rf_b;
    dec.pcv  = pc;
    dec.rs1  = f_rs1;
    dec.rs2  = f_rs2;
    dec.rd   = f_rd;
    unique case (1'b1)
      is_r:  dec.ctrl = CTRL_R;
      is_i:  begin dec.ctrl = CTRL_I;  dec.imm = imm_i; end
      is_ld: begin dec.ctrl = CTRL_LD; dec.imm = imm_i; end
      is_st: begin dec.ctrl = CTRL_ST; dec.imm = imm_s; end
      is_br: begin dec.ctrl = CTRL_BR; dec.imm = imm_b; end
      default: dec.ill = 1'b1;
    endcase
  end

  assign uses_rs2 = is_r | is_st | is_br;
  assign hazard = in_valid & valid_q & q_q.ctrl[7]
                & (q_q.rd != 5'd0)
                & ((q_q.rd == f_rs1)
                 | (uses_rs2 & (q_q.rd == f_rs2)));
  assign adv      = !valid_q | ex_ready;
  assign in_ready = adv & !hazard & !rst;
  assign xfer     = in_valid & in_ready & !flush;

  // a dropped slot clears ctrl so nothing downstream writes
  always_comb begin
    q_d     = q_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d  = 1'b0;
      q_d.ctrl = '0;
      q_d.ill  = 1'b0;
    end else if (xfer) begin
      valid_d = 1'b1;
      q_d     = dec;
    end else if (adv) begin
      valid_d  = 1'b0;
      q_d.ctrl = '0;
      q_d.ill  = 1'b0;
    end
    if (hazard && ex_ready && !flush
        && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      q_q     <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 32; i++)
        rf_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      if (wb_we)
        rf_q[wb_rd] <= wb_data;
    end
  end

  assign out_valid = valid_q;
  assign ctrl      = q_q.ctrl;
  assign ill       = q_q.ill;
  assign dataA     = q_q.a;
  assign dataB     = q_q.b;
  assign imm_ext   = q_q.imm;
  assign pc_out    = q_q.pcv;
  assign rs1       = q_q.rs1;
  assign rs2       = q_q.rs2;
  assign rd        = q_q.rd;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: decode table, directed pipeline sequences
// and a randomized run against a behavioural model.
module tb_id_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, flush, wb_en, ex_ready;
  logic [31:0] instruction, pc, wb_data;
  logic [4:0]  wb_rd;

  logic        in_ready, out_valid, ill;
  logic [10:0] ctrl;
  logic [31:0] dataA, dataB, imm_ext, pc_out;
  logic [4:0]  rs1, rs2, rd;
  logic [15:0] stall_cnt;

  logic        in_ready0, out_valid0, ill0;
  logic [10:0] ctrl0;
  logic [31:0] dataA0, dataB0, imm_ext0, pc_out0;
  logic [4:0]  rs10, rs20, rd0;
  logic [15:0] stall_cnt0;

  id_stage_pipe #(.XLEN(32), .NREG(32), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(in_ready), .instruction(instruction),
    .pc(pc), .flush(flush), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_ready(ex_ready), .out_valid(out_valid),
    .ctrl(ctrl), .dataA(dataA), .dataB(dataB),
    .imm_ext(imm_ext), .pc_out(pc_out), .rs1(rs1),
    .rs2(rs2), .rd(rd), .ill(ill),
    .stall_cnt(stall_cnt)
  );

  id_stage_pipe #(.XLEN(32), .NREG(32), .BYPASS(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(in_ready0), .instruction(instruction),
    .pc(pc), .flush(flush), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_ready(ex_ready), .out_valid(out_valid0),
    .ctrl(ctrl0), .dataA(dataA0), .dataB(dataB0),
    .imm_ext(imm_ext0), .pc_out(pc_out0), .rs1(rs10),
    .rs2(rs20), .rd(rd0), .ill(ill0),
    .stall_cnt(stall_cnt0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    wb_en = 1'b0; ex_ready = 1'b1;
    wb_rd = 5'd0; wb_data = 32'd0;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [10:0] c;
    logic        il;
    logic        ichk;
    logic [31:0] imm;
  } vec_t;
  vec_t tv[10];

  // behavioural model state
  logic [31:0] mregs [32];
  bit          mv, mill;
  logic [10:0] mctrl;
  logic [31:0] ma, ma0, mb, mb0, mimm, mpc;
  logic [4:0]  mrs1, mrs2, mrd;
  int          mstall;

  function automatic void spec_dec(input logic [31:0] ins,
                                   output logic [10:0] c,
                                   output bit il,
                                   output logic [31:0] im);
    logic [31:0] si, ss, sb;
    si = 32'($signed(ins) >>> 20);
    ss = (si & 32'hFFFF_FFE0) | ((ins >> 7) & 32'h1F);
    sb = (ins[31] ? 32'hFFFF_F000 : 32'd0)
       | (((ins >> 7) & 32'h1) << 11)
       | (((ins >> 25) & 32'h3F) << 5)
       | (((ins >> 8) & 32'hF) << 1);
    c = 11'd0; il = 1'b0; im = 32'd0;
    case (ins[6:0])
      7'b0110011: c = 11'h410;
      7'b0010011: begin c = 11'h610; im = si; end
      7'b0000011: begin c = 11'h6C0; im = si; end
      7'b0100011: begin c = 11'h301; im = ss; end
      7'b1100011: begin c = 11'h02A; im = sb; end
      default:    il = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a,
                                        input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && wb_en && wb_rd == a) return wb_data;
    return mregs[a];
  endfunction

  function automatic logic [31:0] gen_ins();
    logic [31:0] w;
    logic [6:0]  ops [10];
    ops = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23,
            7'h63, 7'h33, 7'h7F, 7'h37, 7'h6F};
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 9)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  initial begin
    logic [10:0] dc;
    bit          dil;
    logic [31:0] dim;
    bit          haz, rdy, use2;

    tv[0] = '{32'h00408113, 11'h610, 1'b0, 1'b1, 32'h4};
    tv[1] = '{32'hFFF00293, 11'h610, 1'b0, 1'b1, 32'hFFFFFFFF};
    tv[2] = '{32'h00118233, 11'h410, 1'b0, 1'b1, 32'h0};
    tv[3] = '{32'hFFC0A003, 11'h6C0, 1'b0, 1'b1, 32'hFFFFFFFC};
    tv[4] = '{32'h0020A423, 11'h301, 1'b0, 1'b1, 32'h8};
    tv[5] = '{32'hFE20AA23, 11'h301, 1'b0, 1'b1, 32'hFFFFFFF4};
    tv[6] = '{32'h00208863, 11'h02A, 1'b0, 1'b1, 32'h10};
    tv[7] = '{32'hFE208CE3, 11'h02A, 1'b0, 1'b1, 32'hFFFFFFF8};
    tv[8] = '{32'h0000007F, 11'h000, 1'b1, 1'b0, 32'h0};
    tv[9] = '{32'h000000B7, 11'h000, 1'b1, 1'b0, 32'h0};

    idle();
    instruction = 32'd0; pc = 32'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_ill", 32'(ill), 32'd0);

    in_valid = 1'b1; instruction = 32'h00028313;
    tick();
    chk("rst_x5", dataA, 32'd0);
    in_valid = 1'b0;

    // wb x1 then addi x2,x1,4
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h10;
    tick();
    wb_en = 1'b0;
    in_valid = 1'b1; instruction = 32'h00408113;
    pc = 32'h100;
    tick();
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_dataA", dataA, 32'h10);
    chk("addi_imm", imm_ext, 32'h4);
    chk("addi_ctrl", 32'(ctrl), 32'h610);
    chk("addi_pc", pc_out, 32'h100);
    chk("addi_rd", 32'(rd), 32'd2);

    // load-use: lw x3,0(x1) then add x4,x3,x1
    instruction = 32'h0000A183;
    tick();
    chk("lw_ctrl", 32'(ctrl), 32'h6C0);
    instruction = 32'h00118233;
    #1;
    chk("lu_ready0", 32'(in_ready), 32'd0);
    tick();
    chk("lu_bubble", 32'(out_valid), 32'd0);
    chk("lu_bub_ctrl", 32'(ctrl), 32'd0);
    chk("lu_stall", 32'(stall_cnt), 32'd1);
    chk("lu_ready1", 32'(in_ready), 32'd1);
    tick();
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_ctrl", 32'(ctrl), 32'h410);
    chk("add_rs1", 32'(rs1), 32'd3);
    chk("add_dataB", dataB, 32'h10);
    in_valid = 1'b0;
    tick();

    // same-cycle write-back and read of x6
    wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h1111;
    tick();
    wb_data = 32'hABCD;
    in_valid = 1'b1; instruction = 32'h000303B3;
    tick();
    chk("byp1_dataA", dataA, 32'hABCD);
    chk("byp0_dataA", dataA0, 32'h1111);
    wb_en = 1'b0;
    tick();
    chk("byp0_after", dataA0, 32'hABCD);

    // hold under back-pressure, then flush
    instruction = 32'h00408113; pc = 32'h200;
    tick();
    ex_ready = 1'b0;
    instruction = 32'hFFF00293; pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", 32'(in_ready), 32'd0);
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_pc", pc_out, 32'h200);
      chk("hold_dataA", dataA, 32'h10);
      chk("hold_ctrl", 32'(ctrl), 32'h610);
    end
    flush = 1'b1;
    tick();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ctrl", 32'(ctrl), 32'd0);
    ex_ready = 1'b1;
    #1;
    chk("flush_ready", 32'(in_ready), 32'd1);
    tick();
    chk("flush_drop", 32'(out_valid), 32'd0);
    chk("flush_stall", 32'(stall_cnt), 32'd1);
    flush = 1'b0;

    // x0 stays zero, even with same-cycle write-back
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
    instruction = 32'h00000313;
    tick();
    chk("x0_same", dataA, 32'd0);
    wb_en = 1'b0;
    tick();
    chk("x0_after", dataA, 32'd0);

    // decode table
    foreach (tv[k]) begin
      instruction = tv[k].ins;
      tick();
      chk($sformatf("tv%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("tv%0d_ctrl", k), 32'(ctrl), 32'(tv[k].c));
      chk($sformatf("tv%0d_ill", k), 32'(ill), 32'(tv[k].il));
      if (tv[k].ichk)
        chk($sformatf("tv%0d_imm", k), imm_ext, tv[k].imm);
    end

    // randomized run against the model
    idle();
    rst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c != 0) begin
        rst      = ($urandom_range(0, 99) == 0);
        flush    = ($urandom_range(0, 19) == 0);
        in_valid = ($urandom_range(0, 9) < 8);
        ex_ready = ($urandom_range(0, 3) != 0);
        wb_en    = ($urandom_range(0, 1) == 1);
        wb_rd    = 5'($urandom_range(0, 7));
        wb_data  = $urandom;
        instruction = gen_ins();
        pc = $urandom;
      end
      #1;
      use2 = (instruction[6:0] == 7'h33)
          || (instruction[6:0] == 7'h23)
          || (instruction[6:0] == 7'h63);
      haz = in_valid && mv && mctrl[7] && mrd != 5'd0
         && (mrd == instruction[19:15]
          || (use2 && mrd == instruction[24:20]));
      rdy = (!mv || ex_ready) && !haz && !rst;
      if (c != 0)
        chk("r_in_ready", 32'(in_ready), 32'(rdy));

      if (rst) begin
        foreach (mregs[i]) mregs[i] = 32'd0;
        mv = 1'b0; mctrl = 11'd0; mill = 1'b0;
        mstall = 0;
      end else begin
        if (flush) begin
          mv = 1'b0; mctrl = 11'd0; mill = 1'b0;
        end else if (rdy && in_valid) begin
          spec_dec(instruction, dc, dil, dim);
          mv = 1'b1; mctrl = dc; mill = dil; mimm = dim;
          mrs1 = instruction[19:15];
          mrs2 = instruction[24:20];
          mrd  = instruction[11:7];
          ma  = mread(mrs1, 1'b1); ma0 = mread(mrs1, 1'b0);
          mb  = mread(mrs2, 1'b1); mb0 = mread(mrs2, 1'b0);
          mpc = pc;
        end else if (!mv || ex_ready) begin
          mv = 1'b0; mctrl = 11'd0; mill = 1'b0;
        end
        if (haz && ex_ready && !flush && mstall < 65535)
          mstall++;
        if (wb_en && wb_rd != 5'd0)
          mregs[wb_rd] = wb_data;
      end

      tick();
      chk("r_valid", 32'(out_valid), 32'(mv));
      chk("r_ctrl", 32'(ctrl), 32'(mctrl));
      chk("r_stall", 32'(stall_cnt), 32'(mstall));
      if (mv) begin
        chk("r_ill", 32'(ill), 32'(mill));
        chk("r_dataA", dataA, ma);
        chk("r_dataB", dataB, mb);
        chk("r_dataA_nb", dataA0, ma0);
        chk("r_dataB_nb", dataB0, mb0);
        chk("r_imm", imm_ext, mimm);
        chk("r_pc", pc_out, mpc);
        chk("r_rs1", 32'(rs1), 32'(mrs1));
        chk("r_rs2", 32'(rs2), 32'(mrs2));
        chk("r_rd", 32'(rd), 32'(mrd));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
